s_memory_reader: RTL and testbench
==================================

# s_memory_reader

Sequential read-back engine for the 256-byte S memory (single-port synchronous RAM, registered address, one-cycle read latency). On a start pulse it sweeps addresses 0..LAST_ADDR, fetches each byte, and presents it with its address on a valid/ready output stream. It is the read-side counterpart of the S-memory initialization writer and feeds downstream consumers such as the key-schedule datapath, a debug dump, or a checker. An optional compiled-in checker verifies the identity contents left by initialization.

## Interface
Parameters:
- ADDR_W, 8, address width; sweep length is 2^ADDR_W.
- DATA_W, 8, memory data width.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- start  in  1  begin a sweep; sampled only in IDLE.
- address  out  ADDR_W  memory address.
- wren  out  1  memory write enable; constant 0.
- q  in  DATA_W  memory read data, valid one cycle after address is sampled.
- out_data  out  DATA_W  captured byte.
- out_addr  out  ADDR_W  address of out_data.
- out_last  out  1  high with the final byte (out_addr = 2^ADDR_W-1).
- out_valid  out  1  stream valid.
- out_ready  in  1  stream ready.
- busy  out  1  high from READ through DONE.
- done  out  1  one-cycle pulse at end of sweep.
- mismatch  out  1  sticky checker flag.
- err_count  out  ADDR_W+1  checker mismatch count.

## Operation
- Internal counter idx (ADDR_W bits), cleared on entry to READ from IDLE.
- States:
  - IDLE: start=1 -> READ; else stay.
  - READ: address=idx; -> WAIT.
  - WAIT: q valid; register q into out_data and idx into out_addr; out_last = (idx == all ones); -> PRESENT.
  - PRESENT: out_valid=1; out_valid&out_ready -> DONE if out_last, else idx <= idx+1 and -> READ. Otherwise stay.
  - DONE: done=1; -> IDLE.
- address holds idx in every state; it is not changed while PRESENT is stalled.
- out_data, out_addr, and out_last stay stable while out_valid=1 and out_ready=0.
- out_valid falls in the cycle after the transfer.
- start while busy is ignored.
- start held high in IDLE after DONE begins a new sweep from 0.
- idx never wraps in a sweep; the transfer at all-ones ends the sweep.
- wren=0 always; the block never writes memory.

## Timing
- Reset (async, any state): state=IDLE and idx=0. All outputs 0: address, out_data, out_addr, out_last, out_valid, busy, done, mismatch, err_count.
- start sampled at edge E. The next state is READ for cycle E+1.
- Per byte, with out_ready=1, the minimum is 3 cycles: READ, WAIT, PRESENT.
- First out_valid appears 3 cycles after the start edge.
- A full 256-byte sweep with out_ready tied high:
  - done is high in cycle 769 after the start edge.
  - busy is high in cycles 1..769.
- Each stalled PRESENT cycle adds exactly one cycle.
- Reset asserted mid-sweep aborts immediately. No done pulse follows, and checker state clears.

## Configuration
- Macro S_MEM_READ_CHECK_EN.
- Defined:
  - In WAIT, q is compared with the expected value idx (the identity pattern written by init) after truncation/zero-extension to DATA_W.
  - On inequality, mismatch is set (sticky until reset or the next start accepted in IDLE) and err_count increments, saturating at 2^ADDR_W.
  - Both mismatch and err_count clear when a sweep starts.
  - Stream behaviour is unchanged.
- Undefined: mismatch and err_count are tied to 0; no comparator is present.

## Test plan
- Identity memory, out_ready=1, pulse start: 256 transfers with out_addr=out_data=0..255, out_last only at 0xFF, done in cycle 769, busy low afterward.
- Backpressure: hold out_ready=0 for 5 cycles on byte 0x10. out_valid stays high, out_data/out_addr stay 0x10, address stays 0x10, then 0x11 follows; done is 5 cycles later than the baseline.
- Assert reset during PRESENT of byte 0x80: all outputs are 0 next cycle, there is no done pulse, and a new start restarts at address 0.
- Pulse start during busy at byte 0x40: the sweep is unaffected, with exactly one done.
- Start held high continuously: two back-to-back sweeps, with IDLE for one cycle between the done cycle and the next READ.
- S_MEM_READ_CHECK_EN defined, memory[0x3C]=0x00 and memory[0xA5]=0xFF: mismatch rises after byte 0x3C, err_count=2 at done, and both clear on the next start.

Source files
------------

// File: rtl/s_memory_reader.sv
// Sweeps S memory addresses 0..2^ADDR_W-1 and streams {data, addr, last}; optional identity checker under `S_MEM_READ_CHECK_EN.
// Latency: 3 cycles per byte (READ, WAIT, PRESENT); done pulses in cycle 3*2^ADDR_W+1 after the start edge.
// Backpressure: PRESENT holds out_data/out_addr/out_last and address while out_ready is low, one cycle per stall.
module s_memory_reader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] address,
  output logic              wren,
  input  logic [DATA_W-1:0] q,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic              mismatch,
  output logic [ADDR_W:0]   err_count
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_READ    = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_PRESENT = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  logic [2:0]        state;
  logic [2:0]        state_nxt;
  logic [ADDR_W-1:0] idx;
  logic              start_acc;
  logic              xfer;

  assign start_acc = (state == S_IDLE) && start;
  assign xfer      = (state == S_PRESENT) && out_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start) state_nxt = S_READ;
      S_READ:    state_nxt = S_WAIT;
      S_WAIT:    state_nxt = S_PRESENT;
      S_PRESENT: if (out_ready) state_nxt = out_last ? S_DONE : S_READ;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // idx stops at all-ones after the final byte; it is only rewound by the next accepted start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      idx      <= '0;
      out_data <= '0;
      out_addr <= '0;
      out_last <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start_acc) begin
        idx <= '0;
      end else if (xfer && !out_last) begin
        idx <= idx + 1'b1;
      end
      if (state == S_WAIT) begin
        out_data <= q;
        out_addr <= idx;
        out_last <= &idx;
      end
    end
  end

  assign address   = idx;
  assign wren      = 1'b0;
  assign out_valid = (state == S_PRESENT);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);

`ifdef S_MEM_READ_CHECK_EN
  localparam logic [ADDR_W:0] ERR_MAX = {1'b1, {ADDR_W{1'b0}}};

  logic [DATA_W-1:0] expected;

  // Initialization leaves memory[i] == i, truncated or zero-extended to the data width.
  assign expected = DATA_W'(idx);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mismatch  <= 1'b0;
      err_count <= '0;
    end else if (start_acc) begin
      mismatch  <= 1'b0;
      err_count <= '0;
    end else if ((state == S_WAIT) && (q != expected)) begin
      mismatch <= 1'b1;
      if (err_count != ERR_MAX) begin
        err_count <= err_count + 1'b1;
      end
    end
  end
`else
  assign mismatch  = 1'b0;
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_s_memory_reader.sv
// Directed bench for s_memory_reader: synchronous RAM model, queue scoreboard of expected stream beats.
module tb_s_memory_reader;
  localparam int N = 256;

`ifdef S_MEM_READ_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] address;
  logic       wren;
  logic [7:0] q;
  logic [7:0] out_data;
  logic [7:0] out_addr;
  logic       out_last;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
  logic       done;
  logic       mismatch;
  logic [8:0] err_count;

  logic [7:0] mem [0:N-1];

  typedef struct packed {
    logic [7:0] data;
    logic [7:0] addr;
    logic       last;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;

  s_memory_reader #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .address(address), .wren(wren), .q(q),
    .out_data(out_data), .out_addr(out_addr), .out_last(out_last), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .done(done), .mismatch(mismatch), .err_count(err_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) q <= mem[address];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Score the current cycle (inputs already final for the coming edge), then advance one cycle.
  task automatic tick();
    exp_t e;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL stream_extra: observed beat addr 0x%0h expected no beat", out_addr);
      end else begin
        e = sb.pop_front();
        chk("stream_beat", {15'd0, out_data, out_addr, out_last}, {15'd0, e.data, e.addr, e.last});
      end
    end
    if (done) done_cnt++;
    @(negedge clk);
    cyc++;
  endtask

  task automatic push_sweep();
    exp_t e;
    for (int i = 0; i < N; i++) begin
      e.data = mem[i];
      e.addr = 8'(i);
      e.last = (i == N - 1);
      sb.push_back(e);
    end
  endtask

  task automatic begin_sweep();
    push_sweep();
    start = 1'b1;
    cyc = 0;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_present(input logic [7:0] a, input int max);
    int n;
    n = 0;
    while (!(out_valid && out_addr == a) && n < max) begin
      tick();
      n++;
    end
    if (!(out_valid && out_addr == a)) begin
      checks++;
      errors++;
      $error("FAIL wait_present: observed no beat 0x%0h expected within %0d cycles", a, max);
    end
  endtask

  task automatic wait_done(input int max);
    int n;
    n = 0;
    while (!done && n < max) begin
      tick();
      n++;
    end
    if (!done) begin
      checks++;
      errors++;
      $error("FAIL wait_done: observed no done expected within %0d cycles", max);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_address"}, address, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_out_addr"}, out_addr, 0);
    chk({tag, "_out_last"}, out_last, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_mismatch"}, mismatch, 0);
    chk({tag, "_err_count"}, err_count, 0);
    chk({tag, "_wren"}, wren, 0);
  endtask

  initial begin
    for (int i = 0; i < N; i++) mem[i] = 8'(i);
    reset = 1'b1;
    start = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    reset = 1'b0;
    tick();
    tick();

    // Baseline sweep
    done_cnt = 0;
    begin_sweep();
    chk("base_busy_c1", busy, 1);
    chk("base_addr_c1", address, 0);
    tick();
    tick();
    chk("base_first_valid_c3", out_valid, 1);
    wait_done(1000);
    chk("base_done_cycle", cyc, 769);
    chk("base_busy_at_done", busy, 1);
    tick();
    chk("base_busy_after", busy, 0);
    chk("base_done_count", done_cnt, 1);
    chk("base_sb_empty", sb.size(), 0);

    // Backpressure on byte 0x10
    begin_sweep();
    wait_present(8'h10, 100);
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("stall_valid", out_valid, 1);
      chk("stall_data", out_data, 8'h10);
      chk("stall_addr", out_addr, 8'h10);
      chk("stall_mem_addr", address, 8'h10);
    end
    out_ready = 1'b1;
    wait_present(8'h11, 10);
    wait_done(1000);
    chk("stall_done_cycle", cyc, 774);
    tick();
    chk("stall_sb_empty", sb.size(), 0);

    // Reset during PRESENT of byte 0x80
    begin_sweep();
    wait_present(8'h80, 500);
    done_cnt = 0;
    reset = 1'b1;
    #1;
    chk_all_zero("midrst");
    sb.delete();
    tick();
    reset = 1'b0;
    repeat (10) tick();
    chk("midrst_no_done", done_cnt, 0);
    chk("midrst_idle", busy, 0);
    begin_sweep();
    chk("midrst_restart_addr", address, 0);
    chk("midrst_restart_busy", busy, 1);
    wait_done(1000);
    chk("midrst_done_cycle", cyc, 769);
    tick();
    chk("midrst_sb_empty", sb.size(), 0);

    // Start pulsed while busy at byte 0x40
    done_cnt = 0;
    begin_sweep();
    wait_present(8'h40, 300);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(1000);
    chk("busystart_done_cycle", cyc, 769);
    repeat (5) tick();
    chk("busystart_done_count", done_cnt, 1);
    chk("busystart_idle", busy, 0);
    chk("busystart_sb_empty", sb.size(), 0);

    // Start held high: back-to-back sweeps
    done_cnt = 0;
    push_sweep();
    push_sweep();
    start = 1'b1;
    cyc = 0;
    tick();
    wait_done(1000);
    chk("held_done1_cycle", cyc, 769);
    tick();
    chk("held_idle_gap", busy, 0);
    tick();
    chk("held_read2_busy", busy, 1);
    chk("held_read2_addr", address, 0);
    wait_done(1000);
    chk("held_done2_cycle", cyc, 1539);
    start = 1'b0;
    repeat (4) tick();
    chk("held_idle_after", busy, 0);
    chk("held_done_count", done_cnt, 2);
    chk("held_sb_empty", sb.size(), 0);

    // Corrupted identity contents
    mem[8'h3C] = 8'h00;
    mem[8'hA5] = 8'hFF;
    begin_sweep();
    wait_present(8'h3B, 300);
    chk("chk_mm_before", mismatch, 0);
    wait_present(8'h3C, 10);
    chk("chk_mm_at_3c", mismatch, CHK);
    chk("chk_cnt_at_3c", err_count, CHK ? 1 : 0);
    wait_done(1000);
    chk("chk_cnt_at_done", err_count, CHK ? 2 : 0);
    chk("chk_mm_at_done", mismatch, CHK);
    tick();
    tick();
    chk("chk_mm_sticky_idle", mismatch, CHK);
    chk("chk_sb_empty", sb.size(), 0);
    mem[8'h3C] = 8'h3C;
    mem[8'hA5] = 8'hA5;
    begin_sweep();
    chk("chk_mm_cleared", mismatch, 0);
    chk("chk_cnt_cleared", err_count, 0);
    wait_done(1000);
    chk("chk_clean_cnt", err_count, 0);
    tick();
    chk("chk_clean_sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
